ehl_wdt_rst_seq: RTL and testbench

Reset sequencer that consumes the watchdog's reset request and generates the staged system reset. It also drives the watchdog's own reset input, `wdt_reset_n`.
- Sits directly downstream of the APB watchdog, in the always-on domain.
- Merges three reset sources (watchdog, external, software-key) into one timed reset sequence.
- Records the reset cause and a watchdog-reset count.
- Registers are reached over the same generic `wr/rd/addr/wdata/rdata` bus used by the watchdog core.

---
 rtl/ehl_wdt_rst_pkg.sv | 29 ++
 rtl/ehl_wdt_rst_regs.sv | 82 ++++++++
 rtl/ehl_wdt_rst_seq.sv | 103 ++++++++++
 tb/tb_ehl_wdt_rst_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ehl_wdt_rst_pkg.sv
// Shared types and constants for the watchdog reset sequencer: FSM states,
// register word offsets, software reset key and CAUSE bit positions.
package ehl_wdt_rst_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAssert = 2'd1,
    StSettle = 2'd2
  } state_e;

  localparam logic [4:0] OffCause  = 5'h00;
  localparam logic [4:0] OffSwrst  = 5'h04;
  localparam logic [4:0] OffWdtCnt = 5'h08;

  // Registers are word-aligned; decode on addr[4:2] only.
  localparam logic [2:0] IdxCause  = OffCause[4:2];
  localparam logic [2:0] IdxSwrst  = OffSwrst[4:2];
  localparam logic [2:0] IdxWdtCnt = OffWdtCnt[4:2];

  localparam logic [7:0] SwKey = 8'hA5;

  localparam int unsigned CauseBitPor = 0;
  localparam int unsigned CauseBitWdt = 1;
  localparam int unsigned CauseBitSw  = 2;
  localparam int unsigned CauseBitExt = 3;

  localparam logic [3:0] CauseReset = 4'(1 << CauseBitPor);

endpackage

// File: rtl/ehl_wdt_rst_regs.sv
// Register file for the reset sequencer: reset cause capture, watchdog reset
// counter, software key decode and combinational read mux.
module ehl_wdt_rst_regs
  import ehl_wdt_rst_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             idle_i,
  input  logic             wdt_rst_req_i,
  input  logic             ext_rst_req_i,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic [4:0]       addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             sw_trig_o,
  output logic [WIDTH-1:0] rdata_o
);

  logic [3:0] cause_q, cause_d;
  logic [7:0] wdt_cnt_q, wdt_cnt_d;
  logic [2:0] word;
  logic       wr_cause, wr_swrst, wr_wdt_cnt, capture;

  assign word       = addr_i[4:2];
  assign wr_cause   = wr_i && (word == IdxCause);
  assign wr_swrst   = wr_i && (word == IdxSwrst);
  assign wr_wdt_cnt = wr_i && (word == IdxWdtCnt);

  // Key writes only count as a trigger while the sequencer is idle.
  assign sw_trig_o = idle_i && wr_swrst && (wdata_i[7:0] == SwKey);
  assign capture   = idle_i && (wdt_rst_req_i || ext_rst_req_i || sw_trig_o);

  always_comb begin
    cause_d = cause_q;
    if (wr_cause) begin
      cause_d = cause_q & ~wdata_i[3:0];
    end
    // Capture is applied after W1C so it wins a same-cycle collision.
    if (capture) begin
      cause_d              = '0;
      cause_d[CauseBitWdt] = wdt_rst_req_i;
      cause_d[CauseBitSw]  = sw_trig_o;
      cause_d[CauseBitExt] = ext_rst_req_i;
    end else if (!idle_i && ext_rst_req_i) begin
      cause_d[CauseBitExt] = 1'b1;
    end
  end

  always_comb begin
    wdt_cnt_d = wr_wdt_cnt ? 8'h00 : wdt_cnt_q;
    if (capture && wdt_rst_req_i && (wdt_cnt_d != 8'hFF)) begin
      wdt_cnt_d = wdt_cnt_d + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cause_q   <= CauseReset;
      wdt_cnt_q <= 8'h00;
    end else begin
      cause_q   <= cause_d;
      wdt_cnt_q <= wdt_cnt_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (rd_i) begin
      case (word)
        IdxCause:  rdata_o[3:0] = cause_q;
        IdxWdtCnt: rdata_o[7:0] = wdt_cnt_q;
        default:   rdata_o      = '0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{addr_i[1:0], wdata_i[WIDTH-1:8]};

endmodule

// File: rtl/ehl_wdt_rst_seq.sv
// Watchdog reset sequencer: merges watchdog, external and software-key reset
// requests into a timed ASSERT/SETTLE sequence driving sys_rst and wdt_reset_n.
module ehl_wdt_rst_seq
  import ehl_wdt_rst_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned ASSERT_CYCLES = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wdt_rst_req_i,
  input  logic             ext_rst_req_i,
  output logic             sys_rst_o,
  output logic             wdt_reset_n_o,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic [4:0]       addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  localparam logic [CNT_W-1:0] AssertLast = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sys_rst_q, wdt_reset_n_q;
  logic             idle, sw_trig, trigger;

  assign idle    = (state_q == StIdle);
  assign trigger = wdt_rst_req_i || ext_rst_req_i || sw_trig;

  ehl_wdt_rst_regs #(
    .WIDTH(WIDTH)
  ) u_regs (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .idle_i       (idle),
    .wdt_rst_req_i(wdt_rst_req_i),
    .ext_rst_req_i(ext_rst_req_i),
    .wr_i         (wr_i),
    .rd_i         (rd_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .sw_trig_o    (sw_trig),
    .rdata_o      (rdata_o)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (trigger) begin
          state_d = StAssert;
        end
      end
      StAssert: begin
        // External request re-arms and holds the counter at zero.
        if (ext_rst_req_i) begin
          cnt_d = '0;
        end else if (cnt_q == AssertLast) begin
          state_d = StSettle;
          cnt_d   = '0;
        end
      end
      StSettle: begin
        if (ext_rst_req_i) begin
          state_d = StAssert;
          cnt_d   = '0;
        end else if (cnt_q == SettleLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StAssert;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StAssert;
      cnt_q         <= '0;
      sys_rst_q     <= 1'b1;
      wdt_reset_n_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sys_rst_q     <= (state_d != StIdle);
      wdt_reset_n_q <= (state_d != StAssert);
    end
  end

  assign sys_rst_o     = sys_rst_q;
  assign wdt_reset_n_o = wdt_reset_n_q;

endmodule

// File: tb/tb_ehl_wdt_rst_seq.sv
// Self-checking bench for ehl_wdt_rst_seq: directed vectors, multi-cycle corner
// sequences and randomized traffic against a remaining-cycles reference model.
module tb_ehl_wdt_rst_seq;

  localparam int A  = 16;
  localparam int S  = 4;
  localparam int AS = A + S;

  logic        clk = 1'b0;
  logic        reset, wdt, ext, wr, rd;
  logic [4:0]  addr;
  logic [31:0] wdata, rdata;
  logic        sys_rst, wdt_n;

  always #5 clk = ~clk;

  ehl_wdt_rst_seq #(
    .WIDTH        (32),
    .ASSERT_CYCLES(A),
    .SETTLE_CYCLES(S),
    .CNT_W        (8)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .wdt_rst_req_i(wdt),
    .ext_rst_req_i(ext),
    .sys_rst_o    (sys_rst),
    .wdt_reset_n_o(wdt_n),
    .wr_i         (wr),
    .rd_i         (rd),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .rdata_o      (rdata)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: reset cycles still to go, plus register contents.
  int         m_rem   = AS;
  logic [3:0] m_cause = 4'h1;
  int         m_cnt   = 0;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [7:0]  wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic       key;
    logic [3:0] c;
    if (reset) begin
      m_rem   = AS;
      m_cause = 4'h1;
      m_cnt   = 0;
    end else begin
      key = wr && (addr[4:2] == 3'd1) && (wdata[7:0] == 8'hA5);
      c   = m_cause;
      if (wr && addr[4:2] == 3'd0) c = c & ~wdata[3:0];
      if (wr && addr[4:2] == 3'd2) m_cnt = 0;
      if (m_rem == 0) begin
        if (wdt || ext || key) begin
          c = {ext, key, wdt, 1'b0};
          if (wdt && m_cnt < 255) m_cnt++;
          m_rem = AS;
        end
      end else if (ext) begin
        m_rem = AS;
        c[3]  = 1'b1;
      end else begin
        m_rem--;
      end
      m_cause = c;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a[4:2])
      3'd0:    return {28'b0, m_cause};
      3'd2:    return 32'(m_cnt);
      default: return 32'h0;
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("sys_rst", {31'b0, sys_rst}, {31'b0, m_rem > 0});
    chk("wdt_reset_n", {31'b0, wdt_n}, {31'b0, !(m_rem > S)});
  endtask

  task automatic idle_inputs();
    wr = 0; rd = 0; wdt = 0; ext = 0; addr = '0; wdata = '0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    rd = 1; addr = a;
    #1;
    chk(name, rdata, exp);
    rd = 0; addr = '0;
  endtask

  task automatic measure(output int w);
    w = 0;
    while (sys_rst === 1'b1 && w < 200) begin
      w++;
      cycle();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sys_rst !== 1'b0 && n < 200) begin
      n++;
      cycle();
    end
    if (n >= 200) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic write1(input logic [4:0] a, input logic [31:0] d);
    wr = 1; addr = a; wdata = d;
    cycle();
    wr = 0; addr = '0; wdata = '0;
  endtask

  initial begin
    int rise, fall, w, n;
    vecs[0] = '{1'b1, 5'h04, 8'h5A, 5'h00, 32'h1};
    vecs[1] = '{1'b0, 5'h04, 8'h00, 5'h04, 32'h0};
    vecs[2] = '{1'b0, 5'h00, 8'h00, 5'h10, 32'h0};
    vecs[3] = '{1'b0, 5'h00, 8'h00, 5'h01, 32'h1};
    vecs[4] = '{1'b1, 5'h1C, 8'hFF, 5'h00, 32'h1};
    vecs[5] = '{1'b1, 5'h00, 8'h01, 5'h00, 32'h0};
    vecs[6] = '{1'b1, 5'h08, 8'h00, 5'h0B, 32'h0};
    vecs[7] = '{1'b0, 5'h00, 8'h00, 5'h0C, 32'h0};

    idle_inputs();
    reset = 1;
    repeat (3) cycle();
    chk("rst_rdata_idle", rdata, 32'h0);

    // Power-on release timing
    reset = 0;
    rise = -1; fall = -1;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (wdt_n === 1'b1 && rise < 0) rise = i;
      if (sys_rst === 1'b0 && fall < 0) fall = i;
    end
    chk("por_wdt_rise", 32'(rise), 32'd16);
    chk("por_sys_fall", 32'(fall), 32'd20);
    rd_chk("por_cause", 5'h00, 32'h1);
    rd_chk("por_wdt_cnt", 5'h08, 32'h0);

    // Register vectors in IDLE
    for (int i = 0; i < 8; i++) begin
      wr = vecs[i].wr; addr = vecs[i].addr; wdata = {24'h0, vecs[i].wdata};
      cycle();
      wr = 0; addr = '0; wdata = '0;
      rd_chk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
    end

    // Watchdog pulse
    wdt = 1; cycle(); wdt = 0;
    measure(w);
    chk("wdt_width", 32'(w), 32'd20);
    rd_chk("wdt_cause", 5'h00, 32'h2);
    rd_chk("wdt_cnt1", 5'h08, 32'h1);
    for (int i = 0; i < 299; i++) begin
      wdt = 1; cycle(); wdt = 0;
      wait_idle();
    end
    rd_chk("wdt_cnt_sat", 5'h08, 32'hFF);

    // Software key
    write1(5'h04, 32'hA5);
    measure(w);
    chk("sw_width", 32'(w), 32'd20);
    rd_chk("sw_cause", 5'h00, 32'h4);
    write1(5'h04, 32'h5A);
    repeat (5) cycle();
    chk("sw_bad_key", {31'b0, sys_rst}, 32'h0);
    rd_chk("sw_bad_key_cause", 5'h00, 32'h4);

    // Key write during ASSERT is ignored
    wdt = 1; cycle(); wdt = 0;
    repeat (3) cycle();
    write1(5'h04, 32'hA5);
    measure(w);
    chk("key_in_assert_width", 32'(w), 32'd16);
    rd_chk("key_in_assert_cause", 5'h00, 32'h2);

    // External re-arm starting in SETTLE
    wdt = 1; cycle(); wdt = 0;
    repeat (17) cycle();
    chk("in_settle", {30'b0, sys_rst, wdt_n}, 32'h3);
    ext = 1;
    repeat (50) cycle();
    ext = 0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (sys_rst === 1'b1 && n < 100);
    chk("ext_release", 32'(n), 32'd20);
    rd_chk("ext_cause", 5'h00, 32'hA);

    // Simultaneous triggers
    write1(5'h00, 32'hF);
    write1(5'h08, 32'h0);
    rd_chk("clr_cause", 5'h00, 32'h0);
    wdt = 1; ext = 1; cycle(); wdt = 0; ext = 0;
    rd_chk("sim_cause", 5'h00, 32'hA);
    rd_chk("sim_cnt", 5'h08, 32'h1);
    wait_idle();

    // W1C colliding with capture
    wr = 1; addr = 5'h00; wdata = 32'h2; wdt = 1;
    cycle();
    idle_inputs();
    rd_chk("w1c_collide_cause", 5'h00, 32'h2);
    rd_chk("w1c_collide_cnt", 5'h08, 32'h2);
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 400) == 0;
      wdt   = ($urandom % 20) == 0;
      ext   = ($urandom % 40) == 0;
      wr    = ($urandom % 6) == 0;
      rd    = $urandom % 2;
      case ($urandom % 4)
        0: addr = 5'h00;
        1: addr = 5'h04 | 5'($urandom % 4);
        2: addr = 5'h08;
        default: addr = 5'($urandom);
      endcase
      wdata = ($urandom % 2) ? 32'hA5 : $urandom;
      #1;
      chk("rand_rdata", rdata, rd ? model_read(addr) : 32'h0);
      cycle();
    end
    reset = 0;
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
